// File: rtl/mmio_out_bank_pkg.sv
// -----------------------------------------------------------------------------
// mmio_out_bank_pkg
// Shared definitions for the MMIO output bank: the write-operation encoding
// carried on wr_op, the bit positions inside the CTRL register, and the
// address stride between consecutive channel shadow registers.
// -----------------------------------------------------------------------------
package mmio_out_bank_pkg;

   // Read-modify-write flavours a channel write can perform on enabled bytes
   typedef enum logic [1:0] {
      OP_WR  = 2'b00,
      OP_SET = 2'b01,
      OP_CLR = 2'b10,
      OP_TGL = 2'b11
   } wrOp_e;

   // CTRL write bits: bit0 requests a commit, bit1 is the AUTO mode flag
   localparam int CTRL_COMMIT = 0;
   localparam int CTRL_AUTO   = 1;

   // Byte distance between consecutive channel registers in the address map
   localparam int CH_STRIDE = 4;

endpackage

// File: rtl/mmio_out_bank_byte_merge.sv
// -----------------------------------------------------------------------------
// mmio_byte_merge
// Purely combinational byte-granular merge of a bus write into an existing
// register value.  Each byte with its enable set is replaced, OR-ed, AND-ed
// with the inverted mask, or XOR-ed according to op; disabled bytes pass
// through unchanged.
//
// Ports
//   oldVal  in  DATA_W    current register contents
//   data    in  DATA_W    write data, or bit mask for set/clear/toggle
//   be      in  DATA_W/8  byte enables
//   op      in  wrOp_e    operation selector
//   newVal  out DATA_W    merged result
// -----------------------------------------------------------------------------
module mmio_byte_merge
   import mmio_out_bank_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0]   oldVal,
   input  logic [DATA_W-1:0]   data,
   input  logic [DATA_W/8-1:0] be,
   input  wrOp_e               op,
   output logic [DATA_W-1:0]   newVal
);

   localparam int NBytes = DATA_W / 8;

   // Start from the old value so that bytes without an enable are untouched,
   // then apply the selected operation byte by byte where enabled.
   always_comb begin
      newVal = oldVal;
      for (int b = 0; b < NBytes; b++) begin
         if (be[b]) begin
            case (op)
               OP_WR:  newVal[b*8 +: 8] = data[b*8 +: 8];
               OP_SET: newVal[b*8 +: 8] = oldVal[b*8 +: 8] | data[b*8 +: 8];
               OP_CLR: newVal[b*8 +: 8] = oldVal[b*8 +: 8] & ~data[b*8 +: 8];
               OP_TGL: newVal[b*8 +: 8] = oldVal[b*8 +: 8] ^ data[b*8 +: 8];
               default: newVal[b*8 +: 8] = oldVal[b*8 +: 8];
            endcase
         end
      end
   end

endmodule

// File: rtl/mmio_out_bank.sv
// -----------------------------------------------------------------------------
// mmio_out_bank
// Bank of N_CH memory-mapped output channels with shadow/commit semantics.
// Bus writes land in per-channel shadow registers; the visible outputs
// (ch_out) only change on a commit, unless AUTO mode is on, in which case
// every channel write is committed at the same edge.
//
// Address map (relative to BASE_ADDR, stride 4):
//   channel i : BASE_ADDR + 4*i
//   CTRL      : BASE_ADDR + 4*N_CH
//     write: bit0 = commit request, bit1 = AUTO (only when wr_be[0] is set)
//     read : bit0 = AUTO, bit1 = pending
//
// Ports
//   clk          in   clock, all state on rising edge
//   rst          in   synchronous active-high reset
//   wr_en        in   write strobe
//   wr_op        in   00 write, 01 set, 10 clear, 11 toggle
//   addr         in   shared read/write address
//   wr_data      in   write data or bit mask
//   wr_be        in   byte enables
//   rd_en        in   read strobe
//   rd_data      out  read result (zero when rd_valid is low)
//   rd_valid     out  read result valid, one cycle after rd_en
//   ch_out       out  committed channel values, channel i at [i*DATA_W +: DATA_W]
//   pending      out  shadow registers hold uncommitted writes
//   commit_pulse out  one-cycle pulse when ch_out updates
//   err          out  one-cycle pulse after an access to an unmapped address
// -----------------------------------------------------------------------------
module mmio_out_bank
   import mmio_out_bank_pkg::*;
#(
   parameter int                N_CH      = 3,
   parameter int                DATA_W    = 32,
   parameter int                ADDR_W    = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 8'h60
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [1:0]               wr_op,
   input  logic [ADDR_W-1:0]        addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic [DATA_W/8-1:0]      wr_be,
   input  logic                     rd_en,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     rd_valid,
   output logic [N_CH*DATA_W-1:0]   ch_out,
   output logic                     pending,
   output logic                     commit_pulse,
   output logic                     err
);

   localparam int StrideLog = $clog2(CH_STRIDE);
   localparam int SlotW     = ADDR_W - StrideLog;

   logic [ADDR_W-1:0] offset;
   logic [SlotW-1:0]  slot;
   logic              aligned;
   logic              chHit;
   logic              ctrlHit;

   logic [DATA_W-1:0] shadow     [N_CH];
   logic [DATA_W-1:0] shadowNext [N_CH];
   logic [DATA_W-1:0] merged     [N_CH];
   logic [DATA_W-1:0] chReg      [N_CH];
   logic [N_CH-1:0]   wrHit;

   logic              chWrite;
   logic              ctrlWrite;
   logic              doCommit;
   logic              autoUpdate;
   logic              autoOn;
   logic              pendingReg;
   logic [DATA_W-1:0] readVal;
   logic [DATA_W-1:0] rdDataReg;
   logic              rdValidReg;
   logic              commitPulseReg;
   logic              errReg;

   // Address decode: the offset from BASE_ADDR must be stride-aligned, and
   // the slot number then selects a channel or, one past the last channel,
   // the CTRL register.  Anything else is unmapped.
   assign offset  = addr - BASE_ADDR;
   assign slot    = offset[ADDR_W-1:StrideLog];
   assign aligned = (offset[StrideLog-1:0] == '0);
   assign chHit   = aligned && (int'(slot) < N_CH);
   assign ctrlHit = aligned && (int'(slot) == N_CH);

   // A write with no byte enables is a no-op and must not look like a write
   // for pending/AUTO purposes, hence the |wr_be qualifier.
   assign chWrite   = |wrHit;
   assign ctrlWrite = wr_en && ctrlHit && wr_be[0];

   // Commit either on an explicit request, or implicitly when AUTO is being
   // switched on while uncommitted writes are sitting in the shadows.
   assign doCommit   = ctrlWrite &&
                       (wr_data[CTRL_COMMIT] ||
                        (wr_data[CTRL_AUTO] && !autoOn && pendingReg));
   assign autoUpdate = chWrite && autoOn;

   // One merge unit per channel; the shadow's next value is the merge result
   // only for the channel actually addressed this cycle.
   for (genvar i = 0; i < N_CH; i++) begin : gCh
      assign wrHit[i] = wr_en && chHit && (int'(slot) == i) && (|wr_be);

      mmio_byte_merge #(
         .DATA_W (DATA_W)
      ) uMerge (
         .oldVal (shadow[i]),
         .data   (wr_data),
         .be     (wr_be),
         .op     (wrOp_e'(wr_op)),
         .newVal (merged[i])
      );

      assign shadowNext[i]               = wrHit[i] ? merged[i] : shadow[i];
      assign ch_out[i*DATA_W +: DATA_W]  = chReg[i];
   end

   // Read mux built from the current (pre-write) state, so a read and write
   // to the same address in one cycle returns the old value.  CTRL reads
   // back AUTO in bit0 and pending in bit1.
   always_comb begin
      readVal = '0;
      if (ctrlHit) begin
         readVal[0] = autoOn;
         readVal[1] = pendingReg;
      end
      for (int i = 0; i < N_CH; i++) begin
         if (chHit && (int'(slot) == i)) begin
            readVal = shadow[i];
         end
      end
   end

   // Main state register.  Reset wins over everything.  A commit (explicit,
   // implicit or AUTO-driven) copies the post-write shadows to the outputs,
   // so in AUTO mode the written channel appears on ch_out at the same edge.
   // A channel write in manual mode marks the bank as pending.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_CH; i++) begin
            shadow[i] <= '0;
            chReg[i]  <= '0;
         end
         autoOn         <= 1'b0;
         pendingReg     <= 1'b0;
         rdDataReg      <= '0;
         rdValidReg     <= 1'b0;
         commitPulseReg <= 1'b0;
         errReg         <= 1'b0;
      end else begin
         rdValidReg     <= rd_en;
         rdDataReg      <= rd_en ? readVal : '0;
         errReg         <= (wr_en || rd_en) && !(chHit || ctrlHit);
         commitPulseReg <= doCommit || autoUpdate;

         for (int i = 0; i < N_CH; i++) begin
            shadow[i] <= shadowNext[i];
         end

         if (doCommit || autoUpdate) begin
            for (int i = 0; i < N_CH; i++) begin
               chReg[i] <= shadowNext[i];
            end
         end

         if (ctrlWrite) begin
            autoOn <= wr_data[CTRL_AUTO];
         end

         if (doCommit) begin
            pendingReg <= 1'b0;
         end else if (chWrite && !autoOn) begin
            pendingReg <= 1'b1;
         end
      end
   end

   assign rd_data      = rdDataReg;
   assign rd_valid     = rdValidReg;
   assign pending      = pendingReg;
   assign commit_pulse = commitPulseReg;
   assign err          = errReg;

endmodule

// File: tb/tb_mmio_out_bank.sv
// -----------------------------------------------------------------------------
// tb_mmio_out_bank
// Self-checking bench for mmio_out_bank.  Two instances are built: dutA with
// the default 3 x 32-bit channels and dutB with 8 x 16-bit channels.  A
// shared stimulus bus drives whichever one is selected; a word-level model
// of the register bank predicts every output after every edge, and a set of
// hand-computed literal checks pins the model to known answers.
// -----------------------------------------------------------------------------
module tb_mmio_out_bank;
   import mmio_out_bank_pkg::*;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         sel = 1'b0;
   logic         wrEn = 1'b0;
   logic         rdEn = 1'b0;
   logic [1:0]   wrOp = 2'b00;
   logic [7:0]   addr = 8'h00;
   logic [31:0]  wrData = 32'h0;
   logic [3:0]   wrBe = 4'h0;

   logic [31:0]  rdDataA;
   logic         rdValidA, pendingA, pulseA, errA;
   logic [95:0]  chOutA;
   logic [15:0]  rdDataB;
   logic         rdValidB, pendingB, pulseB, errB;
   logic [127:0] chOutB;

   int           total = 0;
   int           bad = 0;

   int           nCh;
   int           dataW;
   logic [31:0]  mask;
   logic [7:0]   badAddr;

   logic [31:0]  mShadow [16];
   logic [31:0]  mOut    [16];
   bit           mAuto, mPend;
   logic [31:0]  eRdData;
   bit           eRdValid, ePulse, eErr;

   // Free-running 10-time-unit clock
   always #5 clk = ~clk;

   mmio_out_bank #(.N_CH(3), .DATA_W(32)) dutA (
      .clk (clk), .rst (rst), .wr_en (wrEn & ~sel), .wr_op (wrOp), .addr (addr),
      .wr_data (wrData), .wr_be (wrBe), .rd_en (rdEn & ~sel),
      .rd_data (rdDataA), .rd_valid (rdValidA), .ch_out (chOutA),
      .pending (pendingA), .commit_pulse (pulseA), .err (errA)
   );

   mmio_out_bank #(.N_CH(8), .DATA_W(16)) dutB (
      .clk (clk), .rst (rst), .wr_en (wrEn & sel), .wr_op (wrOp), .addr (addr),
      .wr_data (wrData[15:0]), .wr_be (wrBe[1:0]), .rd_en (rdEn & sel),
      .rd_data (rdDataB), .rd_valid (rdValidB), .ch_out (chOutB),
      .pending (pendingB), .commit_pulse (pulseB), .err (errB)
   );

   function automatic logic [31:0] dutCh(input int i);
      if (sel) return {16'h0, chOutB[i*16 +: 16]};
      return chOutA[i*32 +: 32];
   endfunction

   function automatic logic [31:0] dutRdData();
      return sel ? {16'h0, rdDataB} : rdDataA;
   endfunction

   function automatic logic dutRdValid(); return sel ? rdValidB : rdValidA; endfunction
   function automatic logic dutPending(); return sel ? pendingB : pendingA; endfunction
   function automatic logic dutPulse();   return sel ? pulseB : pulseA;     endfunction
   function automatic logic dutErr();     return sel ? errB : errA;         endfunction

   function automatic logic [7:0] chAddr(input int i);
      return 8'h60 + 8'(4 * i);
   endfunction

   function automatic logic [7:0] ctrlAddr();
      return 8'h60 + 8'(4 * nCh);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h, expected %h (cfg %0d)", name, act, exp, sel);
      end
   endtask

   // Word-level model of the bank, evaluated with the inputs present at the
   // clock edge.  Byte enables become a bit mask and the operation is applied
   // to whole words; the read result is captured before any write applies.
   task automatic modelStep();
      logic [7:0]  off;
      int          idx;
      bit          isCh, isCtrl, doCommit;
      logic [31:0] bm, opRes;
      if (rst) begin
         for (int i = 0; i < 16; i++) begin
            mShadow[i] = '0;
            mOut[i]    = '0;
         end
         mAuto = 0; mPend = 0;
         eRdData = '0; eRdValid = 0; ePulse = 0; eErr = 0;
         return;
      end
      off    = addr - 8'h60;
      idx    = int'(off) / 4;
      isCh   = (off % 4 == 0) && (idx < nCh);
      isCtrl = (off % 4 == 0) && (idx == nCh);
      ePulse = 0;
      eRdValid = rdEn;
      eRdData  = '0;
      if (rdEn && isCh)   eRdData = mShadow[idx];
      if (rdEn && isCtrl) eRdData = {30'h0, mPend, mAuto};
      eErr = (wrEn || rdEn) && !isCh && !isCtrl;
      bm = '0;
      for (int b = 0; b < dataW / 8; b++) if (wrBe[b]) bm[b*8 +: 8] = 8'hFF;
      if (wrEn && isCh && bm != 0) begin
         case (wrOp)
            2'b00:   opRes = wrData;
            2'b01:   opRes = mShadow[idx] | wrData;
            2'b10:   opRes = mShadow[idx] & ~wrData;
            default: opRes = mShadow[idx] ^ wrData;
         endcase
         mShadow[idx] = (mShadow[idx] & ~bm) | (opRes & bm);
         if (mAuto) begin
            for (int i = 0; i < 16; i++) mOut[i] = mShadow[i];
            ePulse = 1;
         end else begin
            mPend = 1;
         end
      end
      if (wrEn && isCtrl && wrBe[0]) begin
         doCommit = wrData[0] || (wrData[1] && !mAuto && mPend);
         mAuto = wrData[1];
         if (doCommit) begin
            for (int i = 0; i < 16; i++) mOut[i] = mShadow[i];
            mPend  = 0;
            ePulse = 1;
         end
      end
   endtask

   // Compare every observable output of the selected DUT with the model
   task automatic compareModel();
      checkOutput("rd_valid", 32'(dutRdValid()), 32'(eRdValid));
      checkOutput("rd_data", dutRdData(), eRdData);
      checkOutput("pending", 32'(dutPending()), 32'(mPend));
      checkOutput("commit_pulse", 32'(dutPulse()), 32'(ePulse));
      checkOutput("err", 32'(dutErr()), 32'(eErr));
      for (int i = 0; i < nCh; i++)
         checkOutput($sformatf("ch_out[%0d]", i), dutCh(i), mOut[i]);
   endtask

   // Drive one bus cycle, step the model at the edge, then compare #1 later
   task automatic applyStimulus(input logic we, input logic [1:0] op,
                                input logic [7:0] a, input logic [31:0] d,
                                input logic [3:0] be, input logic re);
      wrEn = we; wrOp = op; addr = a; wrData = d; wrBe = be; rdEn = re;
      @(posedge clk);
      modelStep();
      #1;
      compareModel();
      wrEn = 1'b0;
      rdEn = 1'b0;
   endtask

   task automatic idle();
      applyStimulus(1'b0, OP_WR, 8'h00, 32'h0, 4'h0, 1'b0);
   endtask

   task automatic runSuite(input logic cfg);
      sel     = cfg;
      nCh     = cfg ? 8 : 3;
      dataW   = cfg ? 16 : 32;
      mask    = cfg ? 32'h0000_FFFF : 32'hFFFF_FFFF;
      badAddr = cfg ? 8'h84 : 8'h70;
      $display("[TB] suite N_CH=%0d DATA_W=%0d", nCh, dataW);

      rst = 1'b1; idle(); idle(); rst = 1'b0;
      checkOutput("reset pending", 32'(dutPending()), 32'h0);
      checkOutput("reset ch0", dutCh(0), 32'h0);

      applyStimulus(1'b1, OP_WR, chAddr(0), 32'h5, 4'hF, 1'b0);
      checkOutput("manual ch0 held", dutCh(0), 32'h0);
      checkOutput("manual pending", 32'(dutPending()), 32'h1);
      applyStimulus(1'b1, OP_WR, ctrlAddr(), 32'h1, 4'h1, 1'b0);
      checkOutput("commit ch0", dutCh(0), 32'h5);
      checkOutput("commit pulse", 32'(dutPulse()), 32'h1);
      checkOutput("commit pending", 32'(dutPending()), 32'h0);
      idle();
      checkOutput("pulse one cycle", 32'(dutPulse()), 32'h0);

      applyStimulus(1'b1, OP_WR,  chAddr(1), 32'hFFFF_0000, 4'hF, 1'b0);
      applyStimulus(1'b1, OP_SET, chAddr(1), 32'h0000_00FF, 4'h1, 1'b0);
      applyStimulus(1'b0, OP_WR,  chAddr(1), 32'h0, 4'h0, 1'b1);
      checkOutput("set ch1", dutRdData(), 32'hFFFF_00FF & mask);
      applyStimulus(1'b1, OP_CLR, chAddr(1), 32'hFF00_0000, 4'hF, 1'b0);
      applyStimulus(1'b0, OP_WR,  chAddr(1), 32'h0, 4'h0, 1'b1);
      checkOutput("clear ch1", dutRdData(), 32'h00FF_00FF & mask);
      applyStimulus(1'b1, OP_TGL, chAddr(1), 32'h0000_0001, 4'hF, 1'b0);
      applyStimulus(1'b0, OP_WR,  chAddr(1), 32'h0, 4'h0, 1'b1);
      checkOutput("toggle ch1", dutRdData(), 32'h00FF_00FE & mask);
      checkOutput("toggle valid", 32'(dutRdValid()), 32'h1);

      applyStimulus(1'b1, OP_WR, ctrlAddr(), 32'h2, 4'h1, 1'b0);
      checkOutput("implicit commit pulse", 32'(dutPulse()), 32'h1);
      checkOutput("implicit commit ch1", dutCh(1), 32'h00FF_00FE & mask);
      checkOutput("implicit pending", 32'(dutPending()), 32'h0);
      applyStimulus(1'b1, OP_WR, chAddr(2), 32'hA5, 4'hF, 1'b0);
      checkOutput("auto ch2", dutCh(2), 32'hA5);
      checkOutput("auto pulse", 32'(dutPulse()), 32'h1);
      checkOutput("auto pending", 32'(dutPending()), 32'h0);
      applyStimulus(1'b1, OP_WR, chAddr(nCh - 1), 32'h1234, 4'hF, 1'b0);
      applyStimulus(1'b1, OP_WR, ctrlAddr(), 32'h0, 4'h1, 1'b0);
      applyStimulus(1'b1, OP_WR, ctrlAddr(), 32'h2, 4'h1, 1'b0);
      applyStimulus(1'b1, OP_WR, ctrlAddr(), 32'h0, 4'h1, 1'b0);

      applyStimulus(1'b1, OP_WR, chAddr(0), 32'h7, 4'hF, 1'b1);
      checkOutput("read before write", dutRdData(), 32'h5);
      checkOutput("read before write valid", 32'(dutRdValid()), 32'h1);
      applyStimulus(1'b0, OP_WR, chAddr(0), 32'h0, 4'h0, 1'b1);
      checkOutput("read after write", dutRdData(), 32'h7);
      idle();
      checkOutput("rd_data idle zero", dutRdData(), 32'h0);

      applyStimulus(1'b1, OP_WR, ctrlAddr(), 32'h1, 4'h1, 1'b0);
      applyStimulus(1'b1, OP_WR, chAddr(0), 32'hFF, 4'h0, 1'b0);
      checkOutput("be0 no pending", 32'(dutPending()), 32'h0);
      applyStimulus(1'b1, OP_WR, chAddr(0), 32'h1122_3344, 4'h5, 1'b0);
      applyStimulus(1'b0, OP_WR, chAddr(0), 32'h0, 4'h0, 1'b1);
      applyStimulus(1'b0, OP_WR, ctrlAddr(), 32'h0, 4'h0, 1'b1);
      checkOutput("ctrl readback", dutRdData(), 32'h2);

      applyStimulus(1'b1, OP_WR, badAddr, 32'hFFFF_FFFF, 4'hF, 1'b0);
      checkOutput("unmapped write err", 32'(dutErr()), 32'h1);
      applyStimulus(1'b0, OP_WR, badAddr, 32'h0, 4'h0, 1'b1);
      checkOutput("unmapped read data", dutRdData(), 32'h0);
      checkOutput("unmapped read valid", 32'(dutRdValid()), 32'h1);
      checkOutput("unmapped read err", 32'(dutErr()), 32'h1);
      applyStimulus(1'b1, OP_WR, 8'h61, 32'hFFFF_FFFF, 4'hF, 1'b0);
      idle();

      applyStimulus(1'b1, OP_WR, chAddr(0), 32'h9, 4'hF, 1'b0);
      applyStimulus(1'b1, OP_WR, ctrlAddr(), 32'h1, 4'h1, 1'b0);
      rst = 1'b1; idle(); rst = 1'b0;
      checkOutput("reset after commit ch0", dutCh(0), 32'h0);
      checkOutput("reset after commit pulse", 32'(dutPulse()), 32'h0);
      checkOutput("reset after commit pending", 32'(dutPending()), 32'h0);
      rst = 1'b1;
      applyStimulus(1'b1, OP_WR, chAddr(1), 32'hDEAD, 4'hF, 1'b0);
      rst = 1'b0;
      applyStimulus(1'b0, OP_WR, chAddr(1), 32'h0, 4'h0, 1'b1);
      checkOutput("reset beats write", dutRdData(), 32'h0);
      idle();
   endtask

   // Run both configurations back to back, then report
   initial begin
      nCh = 3; dataW = 32; mask = 32'hFFFF_FFFF; badAddr = 8'h70;
      runSuite(1'b0);
      runSuite(1'b1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mmio_out_bank.md
MMIO_OUT_BANK -- requirements
Module: mmio_out_bank

Interface
REQ-001 The block SHALL take parameter N_CH, default 3: number of output channels, range 1..16.
REQ-002 The block SHALL take parameter DATA_W, default 32: channel width, a multiple of 8.
REQ-003 The block SHALL take parameter ADDR_W, default 8: bus address width.
REQ-004 The block SHALL take parameter BASE_ADDR, default 8'h60: address of channel 0.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port wr_en, input, 1 bit: write strobe, one write per cycle when high.
REQ-008 The block SHALL have port wr_op, input, 2 bits: 00 write, 01 set, 10 clear, 11 toggle.
REQ-009 The block SHALL have port addr, input, ADDR_W bits: shared read/write address.
REQ-010 The block SHALL have port wr_data, input, DATA_W bits: write data, or bit mask for set/clear/toggle.
REQ-011 The block SHALL have port wr_be, input, DATA_W/8 bits: byte enables.
REQ-012 The block SHALL have port rd_en, input, 1 bit: read strobe.
REQ-013 The block SHALL have port rd_data, output, DATA_W bits: read result.
REQ-014 The block SHALL have port rd_valid, output, 1 bit: rd_data is valid.
REQ-015 The block SHALL have port ch_out, output, N_CH*DATA_W bits: committed channel values, channel i at bits [i*DATA_W +: DATA_W].
REQ-016 The block SHALL have port pending, output, 1 bit: the shadow registers differ in write history from the committed outputs.
REQ-017 The block SHALL have port commit_pulse, output, 1 bit: one-cycle pulse when the outputs update.
REQ-018 The block SHALL have port err, output, 1 bit: one-cycle pulse on an access to an unmapped address.

Function
REQ-019 The address map SHALL be: channel i shadow register at BASE_ADDR+4*i; CTRL at BASE_ADDR+4*N_CH; all other addresses unmapped.
REQ-020 A channel write SHALL update only the enabled bytes of the shadow register: write replaces the byte, set ORs the mask, clear ANDs the inverted mask, toggle XORs the mask.
REQ-021 A CTRL write SHALL ignore wr_op and wr_be[3:1]; with wr_be[0] set, bit1 sets AUTO and bit0=1 requests a commit.
REQ-022 With AUTO=0, a channel write SHALL set pending, and ch_out SHALL stay unchanged until a commit.
REQ-023 A commit SHALL copy all shadow registers to ch_out at the next edge, clear pending, and assert commit_pulse for exactly one cycle, in the cycle after the commit write.
REQ-024 With AUTO=1, a channel write SHALL update the shadow register and ch_out at the same edge, assert commit_pulse, and leave pending at 0.
REQ-025 A channel write in the same cycle as a commit is impossible, because the block accepts one address per cycle.
REQ-026 When AUTO changes from 0 to 1 while pending=1, the block SHALL perform an implicit commit at the same edge.
REQ-027 A read SHALL have 1-cycle latency: rd_valid goes high the cycle after rd_en, with rd_data = shadow[i], or for CTRL = {zeros, pending, AUTO} in bits [1:0].
REQ-028 rd_data SHALL be 0 whenever rd_valid=0.
REQ-029 When wr_en and rd_en are high on the same address in the same cycle, the read SHALL return the value before the write.
REQ-030 An unmapped write SHALL be ignored, an unmapped read SHALL return 0 with rd_valid high, and either SHALL pulse err in the cycle after the access.
REQ-031 Partial byte enables SHALL leave the disabled bytes unchanged, and wr_be=0 SHALL be a no-op that does not set pending.

Reset
REQ-032 When rst is high at a clock edge, the block SHALL clear all shadow registers, ch_out, AUTO, pending, rd_data, rd_valid, commit_pulse and err to 0.
REQ-033 Reset SHALL take priority over a concurrent write, read or commit.
REQ-034 A commit that is mid-operation at reset SHALL be dropped, with no commit_pulse.

Structure
REQ-035 A shared package SHALL define the wr_op encodings (OP_WR, OP_SET, OP_CLR, OP_TGL), the CTRL bit positions (CTRL_COMMIT=0, CTRL_AUTO=1), and the channel stride 4.
REQ-036 The block SHALL instantiate one sub-module, mmio_byte_merge, a combinational merge of (old, data, be, op) into new, instantiated once per channel.
REQ-037 The address decode and CTRL logic SHALL reside in the top-level module.

Verification
REQ-038 Reset, then write ch0=32'h0000_0005 with AUTO=0 -> ch_out ch0 stays 0 and pending=1; write CTRL=1 -> next cycle ch0=5, commit_pulse=1 for one cycle, pending=0.
REQ-039 ch1=32'hFFFF_0000: set mask 32'h0000_00FF with be=4'b0001 -> 32'hFFFF_00FF; clear 32'hFF00_0000 with be=4'b1111 -> 32'h00FF_00FF; toggle 32'h1 -> 32'h00FF_00FE.
REQ-040 Write CTRL=2 (AUTO=1) with pending=1 -> implicit commit; then write ch2=32'hA5 -> ch_out ch2=32'hA5 at the same edge with commit_pulse.
REQ-041 Same-cycle write ch0=7 and read ch0 while ch0=5 -> rd_data=5 with rd_valid; a read the next cycle -> 7.
REQ-042 Write to addr 8'h70 (N_CH=3) -> err pulse and no state change; read 8'h70 -> rd_data=0, rd_valid=1, err=1.
REQ-043 Assert rst in the cycle after a CTRL commit write -> ch_out=0, commit_pulse=0, pending=0; repeat the whole suite with N_CH=8 and DATA_W=16.
